// File: rtl/msg_pkg.sv
// Shared definitions for the message path: frame constants and the UART TX state encoding.
package msg_pkg;

  // Message framing bytes produced by msg_write and carried over the UART link.
  localparam logic [7:0]  MSG_HDR_WR      = 8'h5A;
  localparam logic [7:0]  MSG_HDR_RD      = 8'h5B;
  localparam logic [7:0]  MSG_TAIL_WR     = 8'hA5;
  localparam logic [7:0]  MSG_TAIL_RD     = 8'hA4;
  localparam int unsigned MSG_FRAME_BYTES = 10;

  // UART transmitter states; codes 6 and 7 are illegal and recover to StIdle.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StLoad  = 3'd2,
    StStart = 3'd3,
    StData  = 3'd4,
    StStop  = 3'd5
  } tx_state_e;

  // Clocks per serial bit, truncating.
  function automatic int unsigned calc_baud_div(input int unsigned clk_hz,
                                                input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..BAUD_DIV-1 while enabled and flags the terminal count.
module uart_baud_cnt #(
  parameter int unsigned BAUD_DIV = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int unsigned     CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-run within one bit period; clear has priority so a new frame starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign bit_end = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/msg_uart_tx.sv
// Message TX FIFO drain: pops one byte at a time and sends it as UART 8N1, LSB first.
module msg_uart_tx
  import msg_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned BAUD_DIV    = calc_baud_div(CLK_FREQ_HZ, BAUD_RATE)
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST_N,
  input  logic        TX_EN,
  input  logic        TX_FIFO_EMPTY,
  input  logic [7:0]  TX_FIFO_Q,
  output logic        TX_FIFO_RD,
  output logic        UART_TXD,
  output logic        TX_BUSY,
  output logic        TX_DONE,
  output logic [15:0] TX_BYTE_CNT
);

  tx_state_e   state;
  logic [7:0]  shift;
  logic [2:0]  bit_cnt;
  logic        txd;
  logic        done;
  logic [15:0] byte_cnt;

  logic        baud_clear;
  logic        baud_enable;
  logic        bit_end;

  // Timer restarts while loading so the start bit gets a full period.
  assign baud_clear  = (state == StLoad);
  assign baud_enable = (state == StStart) || (state == StData) || (state == StStop);

  uart_baud_cnt #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_cnt (
    .clk     (OPB_CLK),
    .rst_n   (OPB_RST_N),
    .clear   (baud_clear),
    .enable  (baud_enable),
    .bit_end (bit_end)
  );

  // Transmit FSM with registered line, done strobe, shift register and byte counter.
  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      state    <= StIdle;
      txd      <= 1'b1;
      shift    <= '0;
      bit_cnt  <= '0;
      done     <= 1'b0;
      byte_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          txd <= 1'b1;
          // Empty is only sampled here, so the FIFO can never be popped while empty.
          if (TX_EN && !TX_FIFO_EMPTY) begin
            state <= StFetch;
          end
        end
        StFetch: begin
          state <= StLoad;
        end
        StLoad: begin
          // FIFO read data is valid one cycle after the strobe.
          shift <= TX_FIFO_Q;
          txd   <= 1'b0;
          state <= StStart;
        end
        StStart: begin
          if (bit_end) begin
            txd     <= shift[0];
            bit_cnt <= '0;
            state   <= StData;
          end
        end
        StData: begin
          if (bit_end) begin
            shift   <= {1'b0, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              txd   <= 1'b1;
              state <= StStop;
            end else begin
              txd <= shift[1];
            end
          end
        end
        StStop: begin
          if (bit_end) begin
            done     <= 1'b1;
            byte_cnt <= byte_cnt + 16'd1;
            state    <= StIdle;
          end
        end
        default: begin
          txd   <= 1'b1;
          state <= StIdle;
        end
      endcase
    end
  end

  assign TX_FIFO_RD  = (state == StFetch);
  assign TX_BUSY     = (state != StIdle);
  assign UART_TXD    = txd;
  assign TX_DONE     = done;
  assign TX_BYTE_CNT = byte_cnt;

endmodule

// File: tb/tb_msg_uart_tx.sv
// Self-checking bench for msg_uart_tx: FIFO model, UART decoder with expected-byte scoreboard.
module tb_msg_uart_tx;

  localparam int unsigned BD  = 10;
  localparam int          GAP = 10 * BD + 3;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        tx_en      = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_q     = 8'h00;
  logic        fifo_rd;
  logic        txd;
  logic        busy;
  logic        done;
  logic [15:0] byte_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int rd_cnt = 0;

  logic [7:0] fifo[$];
  logic [7:0] exp_q[$];

  bit mon_en     = 1'b1;
  bit chk_gap    = 1'b0;
  int last_start = -1;

  msg_uart_tx #(
    .CLK_FREQ_HZ (1_000_000),
    .BAUD_RATE   (100_000)
  ) dut (
    .OPB_CLK       (clk),
    .OPB_RST_N     (rst_n),
    .TX_EN         (tx_en),
    .TX_FIFO_EMPTY (fifo_empty),
    .TX_FIFO_Q     (fifo_q),
    .TX_FIFO_RD    (fifo_rd),
    .UART_TXD      (txd),
    .TX_BUSY       (busy),
    .TX_DONE       (done),
    .TX_BYTE_CNT   (byte_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Standard-mode FIFO: data appears the cycle after the read strobe.
  always @(posedge clk) begin : fifo_model
    logic [7:0] b;
    if (fifo_rd) begin
      rd_cnt <= rd_cnt + 1;
      n_cmp++;
      if (fifo.size() == 0) begin
        n_fail++;
        $display("FAIL underflow: read strobe with fifo size %0d, required >0", fifo.size());
      end else begin
        b = fifo.pop_front();
        fifo_q     <= b;
        fifo_empty <= (fifo.size() == 0);
      end
    end
  end

  // UART decoder: samples mid-bit and compares against the expected-byte queue.
  initial begin : monitor
    logic       prev;
    logic [9:0] bits;
    logic [7:0] exp_b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && prev && !txd) begin
        if (chk_gap && last_start >= 0) begin
          n_cmp++;
          if (cyc - last_start != GAP) begin
            n_fail++;
            $display("FAIL start_gap: got %0d cycles, required %0d", cyc - last_start, GAP);
          end
        end
        last_start = cyc;
        repeat (4) @(negedge clk);
        bits[0] = txd;
        for (int i = 1; i < 10; i++) begin
          repeat (BD) @(negedge clk);
          bits[i] = txd;
        end
        n_cmp++;
        if (bits[0] !== 1'b0 || bits[9] !== 1'b1) begin
          n_fail++;
          $display("FAIL framing: start=%b stop=%b, required start=0 stop=1", bits[0], bits[9]);
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_byte: got %h, required no frame", bits[8:1]);
        end else begin
          exp_b = exp_q.pop_front();
          if (bits[8:1] !== exp_b) begin
            n_fail++;
            $display("FAIL data_byte: got %h, required %h", bits[8:1], exp_b);
          end
        end
      end
      prev = txd;
    end
  end

  task automatic push(input logic [7:0] b, input bit expect_it);
    fifo.push_back(b);
    fifo_empty = 1'b0;
    if (expect_it) exp_q.push_back(b);
  endtask

  task automatic wait_txd_low(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (txd === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (txd !== 1'b1)      begin n_fail++; $display("FAIL rst_txd: got %b, required 1", txd); end
    n_cmp++; if (fifo_rd !== 1'b0)  begin n_fail++; $display("FAIL rst_rd: got %b, required 0", fifo_rd); end
    n_cmp++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
    n_cmp++; if (done !== 1'b0)     begin n_fail++; $display("FAIL rst_done: got %b, required 0", done); end
    n_cmp++; if (byte_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_cnt: got %h, required 0000", byte_cnt); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    int t_rd, t_fall, t_done, r0;
    bit ok;
    r0 = rd_cnt;
    t_rd = 0;
    push(8'h5A, 1'b1);
    @(negedge clk);
    tx_en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_rd === 1'b1) begin
        ok = 1'b1;
        t_rd = cyc;
        break;
      end
    end
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_rd: no read strobe, required one"); end
    wait_txd_low(10, ok);
    t_fall = cyc;
    n_cmp++;
    if (!ok || t_fall - t_rd != 2) begin
      n_fail++; $display("FAIL single_latency: got %0d (ok=%0d), required 2", t_fall - t_rd, ok);
    end
    wait_done(120, ok);
    t_done = cyc;
    n_cmp++;
    if (!ok || t_done - t_fall != 10 * BD) begin
      n_fail++; $display("FAIL single_done_time: got %0d, required %0d", t_done - t_fall, 10 * BD);
    end
    n_cmp++; if (byte_cnt !== 16'd1) begin n_fail++; $display("FAIL single_cnt: got %0d, required 1", byte_cnt); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got %b, required 0", done); end
    n_cmp++; if (rd_cnt - r0 != 1) begin n_fail++; $display("FAIL single_rd_count: got %0d, required 1", rd_cnt - r0); end
  endtask

  task automatic test_frame;
    logic [7:0]  frame [10] = '{8'h5A, 8'h00, 8'h00, 8'h10, 8'h04,
                                8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hA5};
    logic [15:0] cnt0;
    int          r0;
    bit          ok, idle_ok;
    tx_en = 1'b0;
    @(negedge clk);
    cnt0 = byte_cnt;
    foreach (frame[i]) push(frame[i], 1'b1);
    chk_gap    = 1'b1;
    last_start = -1;
    tx_en      = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 * GAP + 50; i++) begin
      @(negedge clk);
      if (byte_cnt === cnt0 + 16'd10) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL frame_cnt: got %0d, required %0d", byte_cnt, cnt0 + 16'd10); end
    r0 = rd_cnt;
    idle_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || txd !== 1'b1) idle_ok = 1'b0;
    end
    n_cmp++; if (!idle_ok) begin n_fail++; $display("FAIL frame_idle: busy=%b txd=%b, required 0/1", busy, txd); end
    n_cmp++; if (rd_cnt != r0) begin n_fail++; $display("FAIL frame_extra_rd: got %0d, required 0", rd_cnt - r0); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL frame_drain: got %0d left, required 0", exp_q.size()); end
    chk_gap = 1'b0;
  endtask

  task automatic test_gating;
    logic [15:0] cnt0;
    int          r0;
    bit          hi, ok;
    tx_en = 1'b1;
    r0    = rd_cnt;
    cnt0  = byte_cnt;
    hi    = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (txd !== 1'b1) hi = 1'b0;
    end
    n_cmp++; if (rd_cnt != r0) begin n_fail++; $display("FAIL gate_empty_rd: got %0d reads, required 0", rd_cnt - r0); end
    n_cmp++; if (!hi) begin n_fail++; $display("FAIL gate_empty_txd: line went low, required high"); end
    tx_en = 1'b0;
    push(8'hA4, 1'b1);
    repeat (30) @(negedge clk);
    n_cmp++; if (rd_cnt != r0) begin n_fail++; $display("FAIL gate_disabled_rd: got %0d reads, required 0", rd_cnt - r0); end
    tx_en = 1'b1;
    wait_done(150, ok);
    n_cmp++;
    if (!ok || byte_cnt !== cnt0 + 16'd1) begin
      n_fail++; $display("FAIL gate_enable_send: got cnt %0d, required %0d", byte_cnt, cnt0 + 16'd1);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_en_drop;
    logic [15:0] cnt0;
    int          r0;
    bit          ok;
    tx_en = 1'b0;
    @(negedge clk);
    cnt0 = byte_cnt;
    r0   = rd_cnt;
    push(8'h61, 1'b1);
    push(8'h62, 1'b0);
    tx_en = 1'b1;
    wait_txd_low(20, ok);
    repeat (30) @(negedge clk);
    tx_en = 1'b0;
    wait_done(150, ok);
    n_cmp++;
    if (!ok || byte_cnt !== cnt0 + 16'd1) begin
      n_fail++; $display("FAIL drop_cnt: got %0d, required %0d", byte_cnt, cnt0 + 16'd1);
    end
    repeat (150) @(negedge clk);
    n_cmp++; if (rd_cnt - r0 != 1) begin n_fail++; $display("FAIL drop_rd: got %0d reads, required 1", rd_cnt - r0); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy: got %b, required 0", busy); end
    n_cmp++; if (byte_cnt !== cnt0 + 16'd1) begin n_fail++; $display("FAIL drop_cnt_hold: got %0d, required %0d", byte_cnt, cnt0 + 16'd1); end
    // Drain the held byte so later tests start with an empty FIFO.
    exp_q.push_back(8'h62);
    tx_en = 1'b1;
    wait_done(150, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL drop_resume: no done, required done"); end
    tx_en = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit ok;
    mon_en = 1'b0;
    push(8'hC3, 1'b0);
    tx_en = 1'b1;
    wait_txd_low(20, ok);
    tx_en = 1'b0;
    // Mid data bit 3, which is 0 for 0xC3.
    repeat (BD + 3 * BD + 4) @(negedge clk);
    n_cmp++; if (txd !== 1'b0) begin n_fail++; $display("FAIL midrst_pre_txd: got %b, required 0", txd); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (txd !== 1'b1) begin n_fail++; $display("FAIL midrst_txd: got %b, required 1", txd); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    n_cmp++; if (byte_cnt !== 16'h0) begin n_fail++; $display("FAIL midrst_cnt: got %h, required 0000", byte_cnt); end
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    push(8'h3C, 1'b1);
    tx_en = 1'b1;
    wait_done(150, ok);
    n_cmp++;
    if (!ok || byte_cnt !== 16'd1) begin
      n_fail++; $display("FAIL midrst_recover: got cnt %0d, required 1", byte_cnt);
    end
    tx_en = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_wrap;
    bit ok;
    tx_en = 1'b0;
    @(negedge clk);
    dut.byte_cnt = 16'hFFFF;
    @(negedge clk);
    n_cmp++; if (byte_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h, required ffff", byte_cnt); end
    push(8'h81, 1'b1);
    tx_en = 1'b1;
    wait_done(150, ok);
    n_cmp++;
    if (!ok || byte_cnt !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_cnt: got %h (done=%0d), required 0000", byte_cnt, ok);
    end
    tx_en = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_frame();
    test_gating();
    test_en_drop();
    test_reset_mid();
    test_wrap();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d bytes outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
